// File: rtl/filter_frame_sequencer_pkg.sv
// Shared types and helpers for the filter frame sequencer.
// Imported by the sequencer top and its output monitor.
package filter_frame_sequencer_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_LPAD,
        S_PIX,
        S_RPAD,
        S_BOT,
        S_FLUSH,
        S_DONE
    } seq_state_e;

    function automatic int border_w(input int kernel);
        return (kernel - 1) / 2;
    endfunction

endpackage

// File: rtl/filter_frame_sequencer_out.sv
// Output-side monitor: counts filter output beats, tracks the sticky
// error flag and qualifies the end-of-frame pulse.
module filter_out_monitor
    import filter_frame_sequencer_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int CNT_W  = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic idle_i,
    input  logic flush_i,
    input  logic done_state_i,
    input  logic beat_i,
    input  logic raw_valid_i,
    input  logic odone_i,
    input  logic timeout_i,
    output logic err_o,
    output logic frame_done_o
);

    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WIDTH * HEIGHT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (beat_i) cnt_d = cnt_q + 1'b1;
        if (clear_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
        // cnt_d already includes a beat arriving alongside oDone
        if (flush_i && odone_i && cnt_d != TOTAL) err_d = 1'b1;
        if (timeout_i) err_d = 1'b1;
        if (idle_i && raw_valid_i) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o        = err_q;
    assign frame_done_o = done_state_i;

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame sequencer: wraps the pixel stream in a zero border for the
// convolution filter, flushes it and forwards its output downstream.
module filter_frame_sequencer
    import filter_frame_sequencer_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int KERNEL_SIZE = 3,
    parameter int FLUSH_MAX   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    output logic             s_ready,
    output logic             f_iValid,
    output logic [PIX_W-1:0] f_iData,
    input  logic             f_oValid,
    input  logic             f_oDone,
    input  logic [PIX_W-1:0] f_oData,
    output logic             m_valid,
    output logic [PIX_W-1:0] m_data,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam int BW      = border_w(KERNEL_SIZE);
    localparam int ROW_LEN = WIDTH + 2 * BW;
    localparam int ROWS    = HEIGHT + 2 * BW;
    localparam int CW      = $clog2(ROW_LEN);
    localparam int RW      = $clog2(ROWS);
    localparam int FW      = $clog2(FLUSH_MAX);

    localparam logic [CW-1:0] COL_LAST   = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0] LPAD_LAST  = CW'(BW - 1);
    localparam logic [CW-1:0] PIX_LAST   = CW'(BW + WIDTH - 1);
    localparam logic [RW-1:0] TOP_LAST   = RW'(BW - 1);
    localparam logic [RW-1:0] IMG_LAST   = RW'(BW + HEIGHT - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_MAX - 1);

    seq_state_e       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic             iv_q, iv_d;
    logic [PIX_W-1:0] idata_q, idata_d;
    logic             row_end;
    logic             timeout;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        flush_d = '0;
        iv_d    = 1'b0;
        idata_d = '0;
        s_ready = 1'b0;
        timeout = 1'b0;
        row_end = (col_q == COL_LAST);
        unique case (state_q)
            S_IDLE: begin
                col_d = '0;
                row_d = '0;
                if (start) state_d = S_TOP;
            end
            S_TOP: begin
                iv_d  = 1'b1;
                col_d = col_q + 1'b1;
                if (row_end) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    if (row_q == TOP_LAST) state_d = S_LPAD;
                end
            end
            S_LPAD: begin
                iv_d  = 1'b1;
                col_d = col_q + 1'b1;
                if (col_q == LPAD_LAST) state_d = S_PIX;
            end
            S_PIX: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    iv_d    = 1'b1;
                    idata_d = s_data;
                    col_d   = col_q + 1'b1;
                    if (col_q == PIX_LAST) state_d = S_RPAD;
                end
            end
            S_RPAD: begin
                iv_d  = 1'b1;
                col_d = col_q + 1'b1;
                if (row_end) begin
                    col_d   = '0;
                    row_d   = row_q + 1'b1;
                    state_d = (row_q == IMG_LAST) ? S_BOT : S_LPAD;
                end
            end
            S_BOT: begin
                iv_d  = 1'b1;
                col_d = col_q + 1'b1;
                if (row_end) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                iv_d    = 1'b1;
                flush_d = flush_q + 1'b1;
                if (f_oDone) begin
                    state_d = S_DONE;
                end else if (flush_q == FLUSH_LAST) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            flush_q <= '0;
            iv_q    <= 1'b0;
            idata_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            flush_q <= flush_d;
            iv_q    <= iv_d;
            idata_q <= idata_d;
        end
    end

    assign f_iValid = iv_q;
    assign f_iData  = idata_q;
    assign busy     = (state_q != S_IDLE);
    assign m_valid  = f_oValid & busy;
    assign m_data   = f_oData;

    filter_out_monitor #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_mon (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start && state_q == S_IDLE),
        .idle_i      (state_q == S_IDLE),
        .flush_i     (state_q == S_FLUSH),
        .done_state_i(state_q == S_DONE),
        .beat_i      (m_valid),
        .raw_valid_i (f_oValid),
        .odone_i     (f_oDone),
        .timeout_i   (timeout),
        .err_o       (err),
        .frame_done_o(frame_done)
    );

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Scoreboard bench for filter_frame_sequencer: a 3x3-kernel and a
// 7x7-kernel instance on a 4x3 frame, with a simple filter model.
module tb_filter_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FM = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [2];
    logic        start      [2];
    logic        s_valid    [2];
    logic [23:0] s_data     [2];
    logic        s_ready    [2];
    logic        f_iValid   [2];
    logic [23:0] f_iData    [2];
    logic        f_oValid   [2];
    logic        f_oDone    [2];
    logic [23:0] f_oData    [2];
    logic        m_valid    [2];
    logic [23:0] m_data     [2];
    logic        busy       [2];
    logic        frame_done [2];
    logic        err        [2];

    filter_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(3), .FLUSH_MAX(FM)
    ) u_dut3 (
        .clk(clk), .reset(rst[0]), .start(start[0]),
        .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
        .f_iValid(f_iValid[0]), .f_iData(f_iData[0]),
        .f_oValid(f_oValid[0]), .f_oDone(f_oDone[0]), .f_oData(f_oData[0]),
        .m_valid(m_valid[0]), .m_data(m_data[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .err(err[0])
    );

    filter_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(7), .FLUSH_MAX(FM)
    ) u_dut7 (
        .clk(clk), .reset(rst[1]), .start(start[1]),
        .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
        .f_iValid(f_iValid[1]), .f_iData(f_iData[1]),
        .f_oValid(f_oValid[1]), .f_oDone(f_oDone[1]), .f_oData(f_oData[1]),
        .m_valid(m_valid[1]), .m_data(m_data[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .err(err[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fbeats [2];

    logic [23:0] sb0 [$];
    logic [23:0] sb1 [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void sb_push(input int u, input logic [23:0] v);
        if (u == 0) sb0.push_back(v);
        else sb1.push_back(v);
    endfunction

    function automatic int sb_size(input int u);
        return (u == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic [23:0] sb_pop(input int u);
        if (u == 0) return sb0.pop_front();
        return sb1.pop_front();
    endfunction

    function automatic void sb_clear(input int u);
        if (u == 0) sb0.delete();
        else sb1.delete();
    endfunction

    // Filter-input beats: frame beats against the scoreboard, then flush zeros
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst[u] !== 1'b1 && f_iValid[u] === 1'b1) begin
                if (sb_size(u) > 0) begin
                    chk("fi_data", f_iData[u], sb_pop(u));
                end else begin
                    chk("flush_zero", f_iData[u], 0);
                    fbeats[u]++;
                end
            end
        end
    end

    task automatic chk_idle(input int u);
        chk("idle_s_ready", s_ready[u], 0);
        chk("idle_f_iValid", f_iValid[u], 0);
        chk("idle_f_iData", f_iData[u], 0);
        chk("idle_m_valid", m_valid[u], 0);
        chk("idle_m_data", m_data[u], 0);
        chk("idle_busy", busy[u], 0);
        chk("idle_frame_done", frame_done[u], 0);
        chk("idle_err", err[u], 0);
    endtask

    // dmode: 0 = no oDone, 1 = oDone with last beat, 2 = oDone one cycle later
    task automatic run_frame(input int u, input bit toggle, input int nret,
                             input int dmode, input bit exp_err,
                             input int abort_at);
        int bw, rl, rs, k, rdy, cyc;
        bit gap, xfer, seen;
        bw = (u == 0) ? 1 : 3;
        rl = W + 2 * bw;
        rs = H + 2 * bw;
        sb_clear(u);
        k = 1;
        for (int r = 0; r < rs; r++) begin
            for (int c = 0; c < rl; c++) begin
                if (r >= bw && r < bw + H && c >= bw && c < bw + W) begin
                    sb_push(u, 24'(k));
                    k++;
                end else begin
                    sb_push(u, 24'h0);
                end
            end
        end
        fbeats[u] = 0;

        @(posedge clk); #1 start[u] = 1'b1;
        @(posedge clk); #1 start[u] = 1'b0;
        @(negedge clk);
        chk("start_err_clr", err[u], 0);
        chk("start_busy", busy[u], 1);
        @(posedge clk); #1;

        k = 0; rdy = 0; cyc = 0; gap = 1'b0;
        while (k < W * H && cyc < 2000) begin
            s_valid[u] = toggle ? (cyc % 2 == 0) : 1'b1;
            s_data[u]  = 24'(k + 1);
            @(negedge clk);
            if (gap) chk("gap_ivalid", f_iValid[u], 0);
            gap  = s_ready[u] && !s_valid[u];
            xfer = s_ready[u] && s_valid[u];
            if (s_ready[u]) rdy++;
            if (xfer && abort_at != 0 && k == abort_at - 1) rst[u] = 1'b1;
            @(posedge clk); #1;
            if (xfer) k++;
            cyc++;
            if (rst[u]) break;
        end
        s_valid[u] = 1'b0;
        s_data[u]  = '0;

        if (rst[u]) begin
            @(negedge clk);
            chk_idle(u);
            rst[u] = 1'b0;
            sb_clear(u);
            return;
        end
        chk("pix_count", k, W * H);
        if (!toggle) chk("ready_cycles", rdy, W * H);

        cyc = 0;
        while (sb_size(u) > 6 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < nret; i++) begin
            @(posedge clk); #1;
            f_oValid[u] = 1'b1;
            f_oData[u]  = 24'h100 + 24'(i);
            f_oDone[u]  = (dmode == 1 && i == nret - 1);
            @(negedge clk);
            chk("m_valid", m_valid[u], 1);
            chk("m_data", m_data[u], 24'h100 + i);
        end
        @(posedge clk); #1;
        f_oValid[u] = 1'b0;
        f_oData[u]  = '0;
        f_oDone[u]  = (dmode == 2);
        if (dmode == 2) begin
            @(posedge clk); #1 f_oDone[u] = 1'b0;
        end

        cyc = 0;
        while (sb_size(u) > 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_drain", sb_size(u), 0);

        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (frame_done[u] === 1'b1);
        end
        chk("done_seen", seen, 1);
        chk("done_busy", busy[u], 1);
        chk("done_err", err[u], exp_err);
        @(negedge clk);
        chk("done_pulse", frame_done[u], 0);
        chk("busy_fall", busy[u], 0);
        chk("err_hold", err[u], exp_err);
        if (dmode == 0) chk("flush_cycles", fbeats[u], FM);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0;
            s_valid[u] = 1'b0; s_data[u] = '0;
            f_oValid[u] = 1'b0; f_oDone[u] = 1'b0; f_oData[u] = '0;
            fbeats[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk_idle(0);
        chk_idle(1);

        run_frame(0, 1'b0, 12, 1, 1'b0, 0);
        run_frame(0, 1'b1, 12, 2, 1'b0, 0);
        run_frame(0, 1'b0, 11, 2, 1'b1, 0);
        run_frame(0, 1'b0, 12, 1, 1'b0, 0);

        @(posedge clk); #1;
        f_oValid[0] = 1'b1;
        f_oData[0]  = 24'hABCDEF;
        @(negedge clk);
        chk("idle_gate_m_valid", m_valid[0], 0);
        @(posedge clk); #1;
        f_oValid[0] = 1'b0;
        f_oData[0]  = '0;
        @(negedge clk);
        chk("idle_valid_err", err[0], 1);

        run_frame(0, 1'b0, 12, 0, 1'b1, 0);
        run_frame(0, 1'b0, 0, 0, 1'b0, 5);
        run_frame(0, 1'b0, 12, 1, 1'b0, 0);
        run_frame(1, 1'b0, 12, 1, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
